seq_divider: RTL

- Multi-cycle signed 32-bit integer divider for the processor ALU's multdiv path.
- Complements the combinational carry-lookahead adder chain: it performs repeated trial subtraction (restoring division), producing one quotient bit per cycle.
- Exposes a start/ready handshake so the pipeline can stall on the result.

---
 rtl/seq_divider.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider
// ---------------------------------------------------------------------------
// Multi-cycle signed integer divider for the ALU multdiv path. It uses
// restoring division on operand magnitudes and produces one quotient bit per
// cycle. The signs are applied to the finished magnitudes.
//
// Handshake: a one-cycle 'start' is accepted only in IDLE, where busy=0.
// While busy=1, start is ignored and the operands in flight do not change.
// 'data_ready' pulses for one cycle when the result is valid. quotient,
// remainder and exception keep their values until the next result or reset.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous active-high reset
//   start       launch pulse, sampled in IDLE
//   dividend    signed dividend, sampled with start
//   divisor     signed divisor, sampled with start
//   quotient    signed quotient, truncated toward zero
//   remainder   signed remainder, same sign as the dividend
//   data_ready  one-cycle result-valid pulse
//   exception   divide-by-zero flag, qualified by data_ready
//   busy        high in DIVIDE and DONE
//   dbg_state   current FSM state (IDLE=0, DIVIDE=1, DONE=2)
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             data_ready,
  output logic             exception,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Datapath registers. dvd_q starts as |dividend|. It shifts left into the
  // partial remainder, and quotient bits enter from the right. After WIDTH
  // iterations it holds the unsigned quotient.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [CNT_W-1:0] cnt_q;

  logic             divisor_zero;
  logic             last_iter;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_signed;
  logic [WIDTH-1:0] rem_signed;

  assign divisor_zero = (divisor == '0);
  assign last_iter    = (cnt_q == CNT_W'(WIDTH - 1));

  // The magnitude of the most negative value wraps to itself. Read as
  // unsigned, that wrapped value is the correct magnitude.
  assign abs_dividend = dividend[WIDTH-1] ? (-dividend) : dividend;
  assign abs_divisor  = divisor[WIDTH-1]  ? (-divisor)  : divisor;

  // One restoring step. The partial remainder is always smaller than the
  // divisor, and the divisor is at most 2^(WIDTH-1). So the shifted value fits
  // in WIDTH+1 bits, and the top bit of the difference is a valid borrow flag.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dsr_q};
  assign trial_ok = ~trial[WIDTH];
  assign rem_next = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {dvd_q[WIDTH-2:0], trial_ok};

  // The sign fix-up is done on the final iteration. The registered result is
  // then already valid in the DONE cycle, when data_ready is high. Negating
  // 0x80000000 gives 0x80000000, which is the required overflow wrap.
  assign quo_signed = (sign_a_q ^ sign_b_q) ? (-quo_next) : quo_next;
  assign rem_signed = sign_a_q ? (-rem_next) : rem_next;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = divisor_zero ? S_DONE : S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // DONE lasts exactly one cycle and is entered once per accepted start.
  // The result-valid pulse can therefore be decoded directly from the state.
  assign data_ready = (state_q == S_DONE);
  assign busy       = (state_q == S_DIVIDE) || (state_q == S_DONE);
  assign dbg_state  = state_q;

  // Datapath and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      exception <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (divisor_zero) begin
              quotient  <= '0;
              remainder <= dividend;
              exception <= 1'b1;
            end else begin
              sign_a_q <= dividend[WIDTH-1];
              sign_b_q <= divisor[WIDTH-1];
              dvd_q    <= abs_dividend;
              dsr_q    <= abs_divisor;
              rem_q    <= '0;
              cnt_q    <= '0;
            end
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_next;
          dvd_q <= quo_next;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            quotient  <= quo_signed;
            remainder <= rem_signed;
            exception <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
